// File: rtl/timer_control.sv
// Sequencing controller for a cascaded BCD down-counter timer chain.
// It issues load/en/clear strobes, prescales the clock into ticks and raises the alarm.
module timer_control #(
  parameter int TICK_DIV    = 100,
  parameter int ALARM_TICKS = 3
) (
  input  logic clk,
  input  logic clear,
  input  logic time_valid,
  input  logic start_stop,
  input  logic cancel,
  input  logic zero,
  output logic load,
  output logic en,
  output logic clr_chain,
  output logic running,
  output logic paused,
  output logic alarm,
  output logic done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] TICK_LAST  = AW'(ALARM_TICKS - 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("timer_control: TICK_DIV must be >= 2");
  end
  if (ALARM_TICKS < 1) begin : g_bad_alarm_ticks
    $error("timer_control: ALARM_TICKS must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADED,
    S_RUN,
    S_PAUSE,
    S_ALARM
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic [AW-1:0] ticks, ticks_next;
  logic          load_next, en_next, clr_next, done_next;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the simulator runs processes.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= S_IDLE;
      presc     <= '0;
      ticks     <= '0;
      load      <= 1'b0;
      en        <= 1'b0;
      clr_chain <= 1'b0;
      running   <= 1'b0;
      paused    <= 1'b0;
      alarm     <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      presc     <= presc_next;
      ticks     <= ticks_next;
      load      <= load_next;
      en        <= en_next;
      clr_chain <= clr_next;
      running   <= (state_next == S_RUN);
      paused    <= (state_next == S_PAUSE);
      alarm     <= (state_next == S_ALARM);
      done      <= done_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    presc_next = presc;
    ticks_next = ticks;
    load_next  = 1'b0;
    en_next    = 1'b0;
    clr_next   = 1'b0;
    done_next  = 1'b0;

    case (state)
      S_IDLE: begin
        // A simultaneous higher-priority command consumes the cycle.
        if (!cancel && !start_stop && time_valid) begin
          load_next  = 1'b1;
          state_next = S_LOADED;
        end
      end

      S_LOADED: begin
        if (cancel) begin
          clr_next   = 1'b1;
          state_next = S_IDLE;
        end else if (start_stop) begin
          if (!zero) begin
            state_next = S_RUN;
            presc_next = '0;
          end
        end else if (time_valid) begin
          load_next = 1'b1;
        end
      end

      S_RUN: begin
        // Expiry is checked before ticking so the chain never borrows past 0.
        if (cancel) begin
          clr_next   = 1'b1;
          state_next = S_IDLE;
          presc_next = '0;
        end else if (zero) begin
          state_next = S_ALARM;
          done_next  = 1'b1;
          presc_next = '0;
          ticks_next = '0;
        end else if (start_stop) begin
          state_next = S_PAUSE;
        end else if (presc == PRESC_LAST) begin
          presc_next = '0;
          en_next    = 1'b1;
        end else begin
          presc_next = presc + PW'(1);
        end
      end

      S_PAUSE: begin
        if (cancel) begin
          clr_next   = 1'b1;
          state_next = S_IDLE;
          presc_next = '0;
        end else if (start_stop) begin
          state_next = S_RUN;
        end
      end

      S_ALARM: begin
        if (cancel || start_stop) begin
          state_next = S_IDLE;
          presc_next = '0;
          ticks_next = '0;
        end else if (presc == PRESC_LAST) begin
          presc_next = '0;
          if (ticks == TICK_LAST) begin
            state_next = S_IDLE;
            ticks_next = '0;
          end else begin
            ticks_next = ticks + AW'(1);
          end
        end else begin
          presc_next = presc + PW'(1);
        end
      end

      default: begin
        state_next = S_IDLE;
        presc_next = '0;
        ticks_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_control.sv
// Randomized and directed bench for timer_control against a cycle-counting
// reference model and an integer model of the digit chain.
module tb_timer_control;

  localparam int TICK_DIV    = 4;
  localparam int ALARM_TICKS = 2;

  logic clk = 1'b0;
  logic clear = 1'b1;
  logic time_valid = 1'b0;
  logic start_stop = 1'b0;
  logic cancel = 1'b0;
  logic zero = 1'b1;
  logic load, en, clr_chain, running, paused, alarm, done;

  always #5 clk = ~clk;

  timer_control #(
    .TICK_DIV   (TICK_DIV),
    .ALARM_TICKS(ALARM_TICKS)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .time_valid(time_valid),
    .start_stop(start_stop),
    .cancel    (cancel),
    .zero      (zero),
    .load      (load),
    .en        (en),
    .clr_chain (clr_chain),
    .running   (running),
    .paused    (paused),
    .alarm     (alarm),
    .done      (done)
  );

  typedef enum {M_IDLE, M_LOADED, M_RUN, M_PAUSE, M_ALARM} mode_t;

  mode_t      m_mode = M_IDLE;
  int         m_run_cycles = 0;
  int         m_alarm_cycles = 0;
  logic [6:0] m_out = '0;

  int chain_value = 0;
  int in_value = 0;
  int cyc = 0;
  int n_pass = 0;
  int n_checks = 0;
  int en_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  // Model: RUN counts elapsed running cycles and ticks on every multiple of
  // TICK_DIV; ALARM lasts ALARM_TICKS*TICK_DIV cycles unless acknowledged.
  task automatic model_step();
    logic l, e, c, d;
    l = 1'b0; e = 1'b0; c = 1'b0; d = 1'b0;
    if (clear) begin
      m_mode = M_IDLE;
      m_run_cycles = 0;
      m_alarm_cycles = 0;
    end else begin
      case (m_mode)
        M_IDLE:
          if (!cancel && !start_stop && time_valid) begin
            l = 1'b1;
            m_mode = M_LOADED;
          end
        M_LOADED:
          if (cancel) begin
            c = 1'b1;
            m_mode = M_IDLE;
          end else if (start_stop) begin
            if (!zero) begin
              m_mode = M_RUN;
              m_run_cycles = 0;
            end
          end else if (time_valid) begin
            l = 1'b1;
          end
        M_RUN:
          if (cancel) begin
            c = 1'b1;
            m_mode = M_IDLE;
          end else if (zero) begin
            d = 1'b1;
            m_mode = M_ALARM;
            m_alarm_cycles = 0;
          end else if (start_stop) begin
            m_mode = M_PAUSE;
          end else begin
            m_run_cycles++;
            if (m_run_cycles % TICK_DIV == 0) e = 1'b1;
          end
        M_PAUSE:
          if (cancel) begin
            c = 1'b1;
            m_mode = M_IDLE;
          end else if (start_stop) begin
            m_mode = M_RUN;
          end
        M_ALARM:
          if (cancel || start_stop) begin
            m_mode = M_IDLE;
          end else begin
            m_alarm_cycles++;
            if (m_alarm_cycles == ALARM_TICKS * TICK_DIV) m_mode = M_IDLE;
          end
        default: m_mode = M_IDLE;
      endcase
    end
    m_out = {l, e, c, m_mode == M_RUN, m_mode == M_PAUSE, m_mode == M_ALARM, d};
  endtask

  // One clock: predict, advance, update the chain model, compare, drop pulses.
  task automatic cycle();
    int nxt;
    model_step();
    if (clear || clr_chain === 1'b1) nxt = 0;
    else if (load === 1'b1) nxt = in_value;
    else if (en === 1'b1 && chain_value > 0) nxt = chain_value - 1;
    else nxt = chain_value;
    @(posedge clk);
    #1;
    chain_value = nxt;
    zero = (chain_value == 0);
    cyc++;
    check("outputs", {25'd0, load, en, clr_chain, running, paused, alarm, done},
          {25'd0, m_out});
    time_valid = 1'b0;
    start_stop = 1'b0;
    cancel = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_load(input int v);
    in_value = v;
    time_valid = 1'b1;
    cycle();
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, n_en, r;

    clear = 1'b1; cycle();
    clear = 1'b1; cycle();
    check("reset_outputs", {25'd0, load, en, clr_chain, running, paused, alarm, done}, 0);

    // Basic load
    in_value = 2; time_valid = 1'b1; cycle();
    check("load_pulse", 32'(load), 1);
    check("load_no_run", 32'(running), 0);
    check("load_no_en", 32'(en), 0);
    cycle();
    check("load_width", 32'(load), 0);

    // Full countdown from 3
    clear = 1'b1; cycle();
    do_load(3);
    start_stop = 1'b1; cycle();
    check("run_rise", 32'(running), 1);
    t0 = cyc;
    en_q.delete();
    for (int i = 0; i < 40 && !alarm; i++) begin
      cycle();
      if (en) en_q.push_back(cyc - t0);
    end
    check("alarm_rise", 32'(alarm), 1);
    check("done_on_entry", 32'(done), 1);
    check("en_count", en_q.size(), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("en_offset_%0d", k), (k < en_q.size()) ? en_q[k] : -1, 4 * (k + 1));
    t1 = cyc;
    cycle();
    check("done_width", 32'(done), 0);
    for (int i = 0; i < 20 && alarm; i++) cycle();
    check("alarm_length", cyc - t1, ALARM_TICKS * TICK_DIV);
    check("idle_after_alarm", {29'd0, running, paused, alarm}, 0);

    // Pause at prescaler 2, resume
    do_load(5);
    start_stop = 1'b1; cycle();
    cycle(); cycle();
    start_stop = 1'b1; cycle();
    check("paused_rise", 32'(paused), 1);
    n_en = 0;
    repeat (20) begin
      cycle();
      if (en) n_en++;
    end
    check("pause_no_en", n_en, 0);
    start_stop = 1'b1; cycle();
    check("resume_running", 32'(running), 1);
    t1 = cyc;
    for (int i = 0; i < 10 && !en; i++) cycle();
    check("resume_en_delay", cyc - t1, 2);

    // cancel beats start_stop in RUN
    cancel = 1'b1; start_stop = 1'b1; cycle();
    check("prio_clr", 32'(clr_chain), 1);
    check("prio_not_paused", 32'(paused), 0);
    check("prio_not_running", 32'(running), 0);
    check("prio_no_en", 32'(en), 0);
    cycle();
    check("prio_clr_width", 32'(clr_chain), 0);
    check("prio_still_idle", {30'd0, paused, en}, 0);

    // Zero start ignored, then early acknowledge of alarm
    do_load(0);
    start_stop = 1'b1; cycle();
    check("zero_start_ignored", 32'(running), 0);
    n_en = 0;
    repeat (6) begin
      cycle();
      if (en) n_en++;
    end
    check("zero_start_no_en", n_en, 0);
    do_load(1);
    start_stop = 1'b1; cycle();
    check("short_run", 32'(running), 1);
    for (int i = 0; i < 20 && !alarm; i++) cycle();
    check("short_alarm", 32'(alarm), 1);
    start_stop = 1'b1; cycle();
    check("ack_alarm_drop", 32'(alarm), 0);
    check("ack_no_clr", 32'(clr_chain), 0);
    check("ack_idle", {30'd0, running, paused}, 0);

    // clear mid-run
    do_load(9);
    start_stop = 1'b1; cycle();
    cycle(); cycle(); cycle();
    clear = 1'b1; cycle();
    check("clear_outputs", {25'd0, load, en, clr_chain, running, paused, alarm, done}, 0);
    start_stop = 1'b1; cycle();
    check("start_after_clear", 32'(running), 0);

    // Random single-command traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(99);
      if (r < 1) clear = 1'b1;
      else if (r < 6) begin
        in_value = $urandom_range(6);
        time_valid = 1'b1;
      end
      else if (r < 11) start_stop = 1'b1;
      else if (r < 13) cancel = 1'b1;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
